// File: rtl/mips32i_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the single-outstanding
// imem request/response handshake and holds one fetched instruction for decode.
module mips32i_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        vld_q, vld_d;

    logic [31:0] pc_inc;
    logic [31:0] redir_tgt;
    logic        req_valid;
    logic        unused_redirect_lsbs;

    assign pc_inc               = pc_q + 32'd4;
    assign redir_tgt            = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A redirect withdraws any request so the stale address never reaches memory.
    always_comb begin
        req_valid = 1'b0;
        case (state_q)
            ST_REQ:  req_valid = !redirect_valid;
            ST_HOLD: req_valid = !stall && !redirect_valid;
            default: req_valid = 1'b0;
        endcase
        if (rst) begin
            req_valid = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        vld_d   = vld_q;
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = imem_resp_valid ? ST_REQ : ST_DROP;
                end else if (imem_resp_valid) begin
                    instr_d = imem_resp_data;
                    pc4_d   = pc_inc;
                    pc_d    = pc_inc;
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    vld_d   = 1'b0;
                    pc_d    = redir_tgt;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    // Consume and issue the next fetch in the same cycle.
                    vld_d   = 1'b0;
                    state_d = imem_req_ready ? ST_WAIT : ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign if_valid       = vld_q;
    assign if_instr       = instr_q;
    assign if_pc_plus4    = pc4_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_mips32i_fetch_ctrl.sv
// Bench for mips32i_fetch_ctrl: memory model plus request/delivery scoreboard.
module tb_mips32i_fetch_ctrl;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc4_q[$];
    logic [31:0] exp_ins_q[$];

    int          lat = 0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    mips32i_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc_plus4     (if_pc_plus4),
        .pc              (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: capture accepted requests, reply after lat extra cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (imem_req_valid === 1'b1 && imem_req_ready) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_req_addr;
            end
        end
    end

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = paddr ^ K;
                    pend            = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard: every accepted request and every consumed instruction is popped.
    initial begin
        logic [31:0] e_addr, e_pc4, e_ins;
        forever begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_req addr=%h", imem_req_addr);
                end else begin
                    e_addr = exp_addr_q.pop_front();
                    if (imem_req_addr !== e_addr) begin
                        errors++;
                        $display("FAIL sb_req_addr got %h exp %h", imem_req_addr, e_addr);
                    end
                end
            end
            if (if_valid === 1'b1 && !stall) begin
                checks++;
                if (exp_pc4_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_deliv pc4=%h instr=%h", if_pc_plus4, if_instr);
                end else begin
                    e_pc4 = exp_pc4_q.pop_front();
                    e_ins = exp_ins_q.pop_front();
                    if (if_pc_plus4 !== e_pc4 || if_instr !== e_ins) begin
                        errors++;
                        $display("FAIL sb_deliv got pc4=%h instr=%h exp pc4=%h instr=%h",
                                 if_pc_plus4, if_instr, e_pc4, e_ins);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_deliv(input logic [31:0] addr);
        exp_pc4_q.push_back(addr + 32'd4);
        exp_ins_q.push_back(addr ^ K);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_addr_q.size() != 0 || exp_pc4_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got req_left=%0d deliv_left=%0d exp 0 0",
                     name, exp_addr_q.size(), exp_pc4_q.size());
            exp_addr_q.delete();
            exp_pc4_q.delete();
            exp_ins_q.delete();
        end
    endtask

    // Leaves the DUT in REQ at pc=tgt with nothing outstanding.
    task automatic park(input logic [31:0] tgt);
        stall          = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        repeat (8) tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
        end
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h exp 00000000", pc);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_if_valid got %b exp 0", if_valid);
        end
        checks++;
        if (if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_if_regs got %h %h exp 0 0", if_instr, if_pc_plus4);
        end
        tick();
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            push_deliv(32'(i * 4));
        end
        lat            = 0;
        imem_req_ready = 1'b1;
        rst            = 1'b0;
        repeat (8) tick();
        imem_req_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            errors++;
            $display("FAIL free_run_next_req got v=%b a=%h exp v=1 a=00000010",
                     imem_req_valid, imem_req_addr);
        end
        check_drained("free_run");
        park(32'h0);
    endtask

    task automatic test_stall_hold();
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        push_deliv(32'h0);
        lat            = 0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b1 || if_pc_plus4 !== 32'h4 || if_instr !== 32'hA5A5_0000 ||
                imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got v=%b pc4=%h ins=%h req=%b exp v=1 pc4=00000004 ins=a5a50000 req=0",
                         if_valid, if_pc_plus4, if_instr, imem_req_valid);
            end
            tick();
        end
        stall = 1'b0;
        tick();
        stall          = 1'b1;
        imem_req_ready = 1'b0;
        park(32'h0);
        check_drained("stall_hold");
    endtask

    task automatic test_redirect_wait_late();
        exp_addr_q.push_back(32'h0);
        lat            = 3;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_req got %b exp 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h100) begin
                errors++;
                $display("FAIL redir_drop got v=%b req=%b pc=%h exp v=0 req=0 pc=00000100",
                         if_valid, imem_req_valid, pc);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_after_drop got req=%b a=%h v=%b exp req=1 a=00000100 v=0",
                     imem_req_valid, imem_req_addr, if_valid);
        end
        tick();
        exp_addr_q.push_back(32'h100);
        push_deliv(32'h100);
        lat            = 0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();
        park(32'h0);
        check_drained("redir_wait");
    endtask

    task automatic test_redirect_coincident();
        exp_addr_q.push_back(32'h0);
        lat            = 0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        exp_addr_q.push_back(32'h200);
        imem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL coinc_resp_discard got v=%b req=%b a=%h exp v=0 req=1 a=00000200",
                     if_valid, imem_req_valid, imem_req_addr);
        end
        tick();
        imem_req_ready = 1'b0;
        stall          = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc_plus4 !== 32'h204 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL coinc_hold got v=%b pc4=%h req=%b exp v=1 pc4=00000204 req=0",
                     if_valid, if_pc_plus4, imem_req_valid);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL coinc_hold_redir_req got %b exp 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || pc !== 32'h200 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL coinc_hold_discard got v=%b pc=%h req=%b a=%h exp v=0 pc=00000200 req=1 a=00000200",
                     if_valid, pc, imem_req_valid, imem_req_addr);
        end
        tick();
        park(32'h40);
        check_drained("coincident");
    endtask

    task automatic test_backpressure();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
                errors++;
                $display("FAIL bp_hold got req=%b a=%h exp req=1 a=00000040",
                         imem_req_valid, imem_req_addr);
            end
            tick();
        end
        exp_addr_q.push_back(32'h40);
        push_deliv(32'h40);
        lat            = 0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_wait_req got %b exp 0", imem_req_valid);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h44) begin
            errors++;
            $display("FAIL bp_next_req got req=%b a=%h exp req=1 a=00000044",
                     imem_req_valid, imem_req_addr);
        end
        park(32'hFFFF_FFFC);
        check_drained("backpressure");
    endtask

    task automatic test_wrap_reset();
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        push_deliv(32'hFFFF_FFFC);
        lat            = 0;
        imem_req_ready = 1'b1;
        tick();
        lat = 3;
        tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc_plus4 !== 32'h0 || if_instr !== 32'h5A5A_FFFC) begin
            errors++;
            $display("FAIL wrap_deliv got v=%b pc4=%h ins=%h exp v=1 pc4=00000000 ins=5a5afffc",
                     if_valid, if_pc_plus4, if_instr);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rst_req got %b exp 0", imem_req_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rst_state got req=%b pc=%h v=%b exp req=0 pc=00000000 v=0",
                     imem_req_valid, pc, if_valid);
        end
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_post_rst got req=%b a=%h exp req=1 a=00000000",
                     imem_req_valid, imem_req_addr);
        end
        tick();
        park(32'h300);
        check_drained("wrap");

        exp_addr_q.push_back(32'h300);
        lat            = 3;
        imem_req_ready = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_rst_req got %b exp 0", imem_req_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || pc !== 32'h0 || if_valid !== 1'b0 ||
            if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL midop_rst_state got req=%b pc=%h v=%b ins=%h pc4=%h exp 0 00000000 0 00000000 00000000",
                     imem_req_valid, pc, if_valid, if_instr, if_pc_plus4);
        end
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL midop_post_rst got req=%b a=%h exp req=1 a=00000000",
                     imem_req_valid, imem_req_addr);
        end
        repeat (6) tick();
        check_drained("midop_rst");
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_hold();
        test_redirect_wait_late();
        test_redirect_coincident();
        test_backpressure();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32i_fetch_ctrl.md
Name: mips32i_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the architectural PC register and drives the instruction-memory request/response handshake.
- Presents fetched instructions, each with its PC+4, to decode. PC+4 feeds the next-PC selection logic.
- Accepts the selected branch/jump target as a redirect, and discards in-flight or held instructions on redirect.
- Supports one outstanding imem request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  decode/backend cannot accept an instruction this cycle
redirect_valid  input  1  taken branch or jump resolved this cycle
redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 00
imem_req_valid  output  1  fetch request valid (combinational from state and inputs)
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  fetch address, equal to pc
imem_resp_valid  input  1  response data valid (one-cycle pulse per accepted request)
imem_resp_data  input  32  instruction word
if_valid  output  1  if_instr/if_pc_plus4 hold a live instruction
if_instr  output  32  fetched instruction (registered)
if_pc_plus4  output  32  address of fetched instruction + 4 (registered)
pc  output  32  current fetch PC register

Behaviour:
- Reset (rst high at a clock edge):
  - pc <= RESET_PC, state <= REQ.
  - if_valid <= 0, if_instr <= 32'h0, if_pc_plus4 <= 32'h0.
  - imem_req_valid is forced to 0 in any cycle where rst is high.
  - Reset mid-transaction abandons it; any later imem_resp_valid is undefined and is not expected by the bench.
- States: REQ, WAIT, HOLD, DROP.
- Handshakes:
  - Request fires when imem_req_valid && imem_req_ready.
  - Instruction is consumed when if_valid && !stall.
- REQ:
  - imem_req_valid = !redirect_valid; imem_req_addr = pc.
  - If redirect_valid: pc <= {redirect_pc[31:2],2'b00}; stay in REQ.
  - Else if imem_req_ready: go to WAIT.
  - Else stay in REQ and hold the address stable.
- WAIT:
  - imem_req_valid = 0.
  - redirect_valid has priority. pc <= redirect target. If imem_resp_valid is also high, discard the response and go to REQ; otherwise go to DROP.
  - Else if imem_resp_valid: if_instr <= imem_resp_data, if_pc_plus4 <= pc+4, pc <= pc+4, if_valid <= 1, go to HOLD.
- HOLD:
  - if_valid = 1.
  - imem_req_valid = !stall && !redirect_valid; imem_req_addr = pc.
  - If redirect_valid (with or without stall): if_valid <= 0, pc <= redirect target, go to REQ.
  - Else if !stall: instruction consumed, if_valid <= 0. Go to WAIT if imem_req_ready, else go to REQ.
  - Else stay in HOLD; all outputs held.
- DROP:
  - imem_req_valid = 0; waits for the stale response.
  - A further redirect_valid updates pc again and stays in DROP (or goes to REQ if imem_resp_valid is high in the same cycle).
  - On imem_resp_valid: discard it, go to REQ.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- Throughput: with zero-latency memory (resp one cycle after request fires) and no stall, one instruction is delivered every 2 cycles.
- Invariants:
  - At most one request is outstanding.
  - if_instr, if_pc_plus4 and if_valid change only on a WAIT response or on a HOLD consume/redirect.
  - imem_req_addr never changes while imem_req_valid=1 && !imem_req_ready, except when a redirect withdraws the request.

Test Plan:
- Reset then free-run: RESET_PC=0, ready=1, resp one cycle after each request, data=addr^32'hA5A5_0000 → requests at 0,4,8,C. if_valid pulses show if_pc_plus4 = 4,8,C,10 with matching if_instr.
- Stall in HOLD: hold stall=1 for 5 cycles after the first instruction → if_instr/if_pc_plus4 stable, imem_req_valid=0. On release the next request goes to addr 4 on the same cycle the instruction is consumed.
- Redirect while WAIT, response 3 cycles late: redirect_pc=32'h0000_0100 → state DROP, late response discarded (if_valid stays 0), next request addr=32'h100, then if_pc_plus4=32'h104.
- Redirect coincident with response in WAIT, and redirect during stalled HOLD: redirect_pc=32'h0000_0203 → response/held instruction discarded, if_valid=0, next request addr=32'h200.
- Memory backpressure: ready=0 for 4 cycles in REQ → imem_req_valid=1 with addr held constant. Then ready=1 → single request, WAIT entered.
- Wrap-around and mid-op reset: redirect to 32'hFFFF_FFFC, fetch → if_pc_plus4=0 and next request addr=0. Then assert rst during WAIT → pc=RESET_PC, if_valid=0, imem_req_valid=0 while rst is high.
